// File: rtl/regfile_sb.sv
// Parametrised register file with per-register busy scoreboard, sequential bulk-clear engine and debug read port.
// Optional write-through read bypass when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wt_addr,
    input  logic [DATA_W-1:0]     wt_data,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic [ADDR_W-1:0]     test_addr,
    output logic [DATA_W-1:0]     test_data
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_W-1:0]             cnt;
    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [DEPTH-1:0]              busy;
    logic                          idle, wt_ok, iss_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle     = (state == IDLE);
    assign wt_ok    = we && idle && !is_zero(wt_addr);
    assign iss_ok   = iss_valid && idle && !is_zero(iss_addr);
    assign clr_busy = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (&cnt)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Issue is applied after write so a same-cycle issue leaves the register busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
            cnt  <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
            cnt       <= cnt + 1'b1;
        end else begin
            if (wt_ok) begin
                regs[wt_addr] <= wt_data;
                busy[wt_addr] <= 1'b0;
            end
            if (iss_ok)
                busy[iss_addr] <= 1'b1;
            if (clr_req) begin
                busy <= '0;
                cnt  <= '0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] lane_data;
        logic              lane_busy;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            lane_data = regs[ra];
            lane_busy = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (wt_ok && (wt_addr == ra)) begin
                lane_data = wt_data;
                lane_busy = iss_ok && (iss_addr == ra);
            end
`endif
            if (is_zero(ra)) begin
                lane_data = '0;
                lane_busy = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = lane_data;
        assign rd_busy[k]                  = lane_busy;
    end

    // Debug port always sees stored contents, never the in-flight write.
    assign test_data = is_zero(test_addr) ? '0 : regs[test_addr];

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU general-purpose register file.
- Configurable data width, depth and read-port count.
- Adds a per-register scoreboard (busy bits) for the pipelined core's hazard unit.
- Adds a sequential bulk-clear engine and a debug read port.
- Sits between decode (reads, issue), writeback (write) and the debug/test path.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1 then register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data, same packing.
- rd_busy  out  NRD  scoreboard busy bit for each rd_addr.
- we  in  1  write enable (writeback).
- wt_addr  in  ADDR_W  write address.
- wt_data  in  DATA_W  write data.
- iss_valid  in  1  issue: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- clr_req  in  1  start bulk clear (pulse).
- clr_busy  out  1  high while the clear engine runs.
- test_addr  in  ADDR_W  debug read address.
- test_data  out  DATA_W  debug read data, no bypass.

Behaviour:
- Reset (rst=0, async):
  - All registers = 0; all busy bits = 0; FSM = IDLE; clr_busy = 0.
  - rd_data and test_data therefore read 0.
- Reads:
  - Combinational, zero latency.
  - If ZERO_REG and address is 0: data = 0, busy = 0.
- Write: at posedge, if we=1 and FSM=IDLE and !(ZERO_REG && wt_addr==0), then reg[wt_addr] <= wt_data and busy[wt_addr] <= 0.
- Issue: at posedge, if iss_valid=1 and FSM=IDLE and !(ZERO_REG && iss_addr==0), then busy[iss_addr] <= 1.
- Issue and write to the same address in the same cycle: data is written and busy ends at 1 (the newer producer wins).
- rd_busy reflects registered busy bits only; there is no same-cycle set/clear forwarding.
- Clear FSM, states IDLE and CLEAR, with counter cnt of ADDR_W bits:
  - IDLE with clr_req=1: next state CLEAR, cnt <= 0, all busy bits <= 0.
  - CLEAR: each cycle reg[cnt] <= 0 and cnt <= cnt+1.
  - When cnt = 2**ADDR_W-1: that register is cleared, then next state IDLE.
  - A clear takes exactly 2**ADDR_W cycles.
  - clr_busy = 1 iff state = CLEAR.
  - In CLEAR, we, iss_valid and clr_req are ignored (dropped, not queued).
  - Reads during CLEAR return current contents, partially cleared.
- Reset asserted mid-clear: immediate return to IDLE with everything zeroed.
- cnt wraps naturally; the terminal compare alone ends CLEAR.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address equals wt_addr while a write is accepted this cycle returns wt_data combinationally (write-through). rd_busy is also forced to 0 in that case unless iss_valid targets the same address.
- Undefined: reads return the pre-write stored value in the write cycle; the new value is visible from the next cycle.
- test_data never bypasses in either build.

Test Plan:
- Reset then read all addresses on both ports and test port -> all 0, rd_busy=0, clr_busy=0.
- we=1, wt_addr=5, wt_data=0xDEADBEEF; next cycle rd_addr port0=5 -> 0xDEADBEEF. Write addr 0 with 0x1234 -> reads 0.
- Same-cycle write addr 7 = 0xA5A5A5A5 with port1 reading 7 (old value 0):
  - BYPASS_EN build -> 0xA5A5A5A5 that cycle.
  - Without the macro -> 0 that cycle, 0xA5A5A5A5 next cycle.
- iss_valid addr 9 -> rd_busy=1 on reading 9 next cycle. Write 9 -> busy 0 after the edge. Issue and write 9 in the same cycle -> busy 1 and data updated.
- Fill regs 1..31 with index values, pulse clr_req:
  - clr_busy high for exactly 32 cycles.
  - A we to addr 3 during clear is dropped.
  - Afterwards all registers read 0 and all busy bits are 0.
- Drop rst low at clear cycle 10 -> clr_busy=0 and all registers 0 immediately. After release, normal writes are accepted on the first edge.
